// File: rtl/modexp_sequencer_if.sv
// Handshake and status bundle between the exponentiation sequencer and its environment
// (command port, modular multiplier, accumulator strobes).
interface modexp_sequencer_if #(
    parameter int unsigned W  = 64,
    parameter int unsigned LW = 32
) ();

    logic          start;
    logic [W-1:0]  exp;
    logic          mul_done;
    logic          mul_start;
    logic          mul_op;
    logic          acc_load_base;
    logic          acc_load_one;
    logic [LW-1:0] msb_idx;
    logic          busy;
    logic          done;

    // Environment side: command source, multiplier response and datapath observer.
    modport master (
        output start,
        output exp,
        output mul_done,
        input  mul_start,
        input  mul_op,
        input  acc_load_base,
        input  acc_load_one,
        input  msb_idx,
        input  busy,
        input  done
    );

    modport slave (
        input  start,
        input  exp,
        input  mul_done,
        output mul_start,
        output mul_op,
        output acc_load_base,
        output acc_load_one,
        output msb_idx,
        output busy,
        output done
    );

endinterface

// File: rtl/modexp_sequencer.sv
// Left-to-right square-and-multiply control FSM: serial MSB scan of the exponent, then one
// square per lower bit plus a multiply for each set lower bit, over a start/done handshake.
module modexp_sequencer #(
    parameter int unsigned W  = 64,
    parameter int unsigned LW = 32
) (
    input logic               clk,
    input logic               rst,
    modexp_sequencer_if.slave bus
);

    localparam int unsigned IW = (W > 1) ? $clog2(W) : 1;

    typedef enum logic [3:0] {
        StIdle,
        StScan,
        StZero,
        StInit,
        StSqReq,
        StSqWait,
        StMulReq,
        StMulWait,
        StFin
    } state_e;

    state_e        state_q, state_d;
    logic [W-1:0]  exp_q, exp_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [LW-1:0] msb_q, msb_d;
    logic          mul_op_q, mul_op_d;

    logic mul_start;
    logic acc_load_base;
    logic acc_load_one;
    logic busy;
    logic done;
    logic advance;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            exp_q    <= '0;
            idx_q    <= '0;
            msb_q    <= '1;
            mul_op_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            exp_q    <= exp_d;
            idx_q    <= idx_d;
            msb_q    <= msb_d;
            mul_op_q <= mul_op_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        exp_d         = exp_q;
        idx_d         = idx_q;
        msb_d         = msb_q;
        mul_op_d      = mul_op_q;
        mul_start     = 1'b0;
        acc_load_base = 1'b0;
        acc_load_one  = 1'b0;
        busy          = 1'b1;
        done          = 1'b0;
        advance       = 1'b0;

        unique case (state_q)
            StIdle: begin
                busy = 1'b0;
                if (bus.start) begin
                    exp_d   = bus.exp;
                    idx_d   = IW'(W - 1);
                    msb_d   = '1;
                    state_d = StScan;
                end
            end
            StScan: begin
                if (exp_q[idx_q]) begin
                    msb_d   = LW'(idx_q);
                    state_d = StInit;
                end else if (idx_q == '0) begin
                    state_d = StZero;
                end else begin
                    idx_d = idx_q - IW'(1);
                end
            end
            StZero: begin
                acc_load_one = 1'b1;
                state_d      = StFin;
            end
            StInit: begin
                acc_load_base = 1'b1;
                if (msb_q == '0) begin
                    state_d = StFin;
                end else begin
                    idx_d   = msb_q[IW-1:0] - IW'(1);
                    state_d = StSqReq;
                end
            end
            StSqReq: begin
                mul_start = 1'b1;
                mul_op_d  = 1'b0;
                state_d   = StSqWait;
            end
            StSqWait: begin
                if (bus.mul_done) begin
                    if (exp_q[idx_q]) begin
                        state_d = StMulReq;
                    end else begin
                        advance = 1'b1;
                    end
                end
            end
            StMulReq: begin
                mul_start = 1'b1;
                mul_op_d  = 1'b1;
                state_d   = StMulWait;
            end
            StMulWait: begin
                if (bus.mul_done) begin
                    advance = 1'b1;
                end
            end
            StFin: begin
                busy    = 1'b0;
                done    = 1'b1;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Step to the next lower exponent bit once the current bit's ops are complete.
        if (advance) begin
            if (idx_q == '0) begin
                state_d = StFin;
            end else begin
                idx_d   = idx_q - IW'(1);
                state_d = StSqReq;
            end
        end
    end

    // mul_op follows the request type and otherwise holds, so it is only meaningful with mul_start.
    assign bus.mul_start     = mul_start;
    assign bus.mul_op        = mul_op_d;
    assign bus.acc_load_base = acc_load_base;
    assign bus.acc_load_one  = acc_load_one;
    assign bus.msb_idx       = msb_q;
    assign bus.busy          = busy;
    assign bus.done          = done;

endmodule

// File: tb/tb_modexp_sequencer.sv
// Self-checking bench for modexp_sequencer: vector table, directed corner sequences and random
// exponents against a square-and-multiply reference model with a behavioural multiplier responder.
module tb_modexp_sequencer;

    localparam int unsigned W  = 64;
    localparam int unsigned LW = 32;
    localparam int BUDGET = W + 2 * W * 8 + 50;

    logic clk;
    logic rst;

    modexp_sequencer_if #(.W(W), .LW(LW)) bus ();

    modexp_sequencer #(.W(W), .LW(LW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Observations of one run.
    int     r_ops[$];
    longint r_code;
    int     r_base, r_one, r_done, r_busy, r_scan, r_dsum, r_min_sp, r_max_sp;
    bit     r_to;
    longint r_msb, r_msb_hold;
    int     r_post;

    typedef struct {
        logic [W-1:0] e;
        int           dly;
        int           msb;
        int           nsq;
        int           nmul;
    } vec_t;

    vec_t vecs[8];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input longint act, input longint req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    function automatic int model_msb(input logic [W-1:0] e);
        int m = -1;
        for (int i = 0; i < W; i++) if (e[i]) m = i;
        return m;
    endfunction

    // Drives one exponentiation and plays the multiplier: mul_done arrives dly cycles after each
    // mul_start (dly = 0 picks 1..4 per op). disturb injects stray start pulses and a stray mul_done.
    task automatic run(input logic [W-1:0] e, input int dly, input bit disturb);
        int pend, cyc, d, last, sp;
        r_ops.delete();
        r_code = 0; r_base = 0; r_one = 0; r_done = 0; r_busy = 0; r_scan = -1; r_dsum = 0;
        r_to = 0; r_min_sp = 1 << 30; r_max_sp = 0; r_msb = -2;
        last = -1; pend = -1; cyc = 0;
        bus.exp = e; bus.start = 1'b1; bus.mul_done = 1'b0;
        step();
        forever begin
            bus.start = 1'b0; bus.exp = e; bus.mul_done = 1'b0;
            if (pend > 0) begin
                pend--;
                if (pend == 0) bus.mul_done = 1'b1;
            end
            if (disturb && cyc == 2) bus.mul_done = 1'b1;
            if (disturb && (cyc == 3 || cyc == last + 1)) begin
                bus.start = 1'b1;
                bus.exp   = ~e;
            end
            if (bus.busy) r_busy++;
            if (bus.acc_load_base) r_base++;
            if (bus.acc_load_one) r_one++;
            if ((bus.acc_load_base || bus.acc_load_one) && r_scan < 0) r_scan = cyc;
            if (bus.mul_start) begin
                r_ops.push_back(int'(bus.mul_op));
                r_code = (r_code << 1) | longint'(bus.mul_op);
                if (last >= 0) begin
                    sp = cyc - last;
                    if (sp < r_min_sp) r_min_sp = sp;
                    if (sp > r_max_sp) r_max_sp = sp;
                end
                last = cyc;
                d = (dly > 0) ? dly : int'($urandom_range(1, 4));
                pend = d;
                r_dsum += d;
            end
            if (bus.done) begin
                r_done++;
                r_msb = longint'($signed(bus.msb_idx));
                break;
            end
            if (cyc >= BUDGET) begin
                r_to = 1'b1;
                break;
            end
            step();
            cyc++;
        end
        bus.start = 1'b0; bus.mul_done = 1'b0;
        step();
        r_post     = int'(bus.busy) + int'(bus.done) + int'(bus.mul_start);
        r_msb_hold = longint'($signed(bus.msb_idx));
    endtask

    task automatic check_run(input string tag, input logic [W-1:0] e, input int dly,
                             input bit disturb);
        int m, bad, scan_exp, n;
        int exp_ops[$];
        run(e, dly, disturb);
        m = model_msb(e);
        for (int i = m - 1; i >= 0; i--) begin
            exp_ops.push_back(0);
            if (e[i]) exp_ops.push_back(1);
        end
        scan_exp = (m < 0) ? int'(W) : int'(W) - m;
        chk({tag, " timeout"}, longint'(r_to), 0);
        chk({tag, " done_count"}, r_done, 1);
        chk({tag, " msb_idx"}, r_msb, m);
        chk({tag, " load_one"}, r_one, (m < 0) ? 1 : 0);
        chk({tag, " load_base"}, r_base, (m < 0) ? 0 : 1);
        chk({tag, " op_count"}, r_ops.size(), exp_ops.size());
        bad = 0;
        n = (r_ops.size() < exp_ops.size()) ? r_ops.size() : exp_ops.size();
        for (int i = 0; i < n; i++) if (r_ops[i] != exp_ops[i]) bad++;
        chk({tag, " op_seq_errors"}, bad, 0);
        chk({tag, " scan_cycles"}, r_scan, scan_exp);
        chk({tag, " busy_cycles"}, r_busy, scan_exp + 1 + exp_ops.size() + r_dsum);
        if (dly > 0 && exp_ops.size() > 1) begin
            chk({tag, " min_spacing"}, r_min_sp, dly + 1);
            chk({tag, " max_spacing"}, r_max_sp, dly + 1);
        end
        chk({tag, " idle_after_fin"}, r_post, 0);
        chk({tag, " msb_idx_hold"}, r_msb_hold, m);
    endtask

    initial begin
        int nsq, nmul, cnt;
        logic [W-1:0] e;

        vecs[0] = '{64'd0, 1, -1, 0, 0};
        vecs[1] = '{64'd1, 2, 0, 0, 0};
        vecs[2] = '{64'd11, 1, 3, 3, 2};
        // Done lands 6 cycles after mul_start (5 wait cycles without it), giving spacing 7.
        vecs[3] = '{64'h8000_0000_0000_0000, 6, 63, 63, 0};
        vecs[4] = '{64'hFFFF_FFFF_FFFF_FFFF, 1, 63, 63, 63};
        vecs[5] = '{64'h8000_0000_0000_0001, 2, 63, 63, 1};
        vecs[6] = '{64'h0000_0000_8000_0000, 3, 31, 31, 0};
        vecs[7] = '{64'h0000_0000_0000_00A5, 0, 7, 7, 3};

        rst = 1'b1; bus.start = 1'b0; bus.exp = '0; bus.mul_done = 1'b0;
        step();
        step();
        chk("reset busy", bus.busy, 0);
        chk("reset done", bus.done, 0);
        chk("reset mul_start", bus.mul_start, 0);
        chk("reset load_base", bus.acc_load_base, 0);
        chk("reset load_one", bus.acc_load_one, 0);
        chk("reset msb_idx", longint'($signed(bus.msb_idx)), -1);
        rst = 1'b0;
        step();

        for (int v = 0; v < 8; v++) begin
            check_run($sformatf("vec%0d", v), vecs[v].e, vecs[v].dly, 1'b0);
            nsq = 0; nmul = 0;
            foreach (r_ops[i]) if (r_ops[i] == 0) nsq++; else nmul++;
            chk($sformatf("vec%0d table_msb", v), r_msb, vecs[v].msb);
            chk($sformatf("vec%0d table_squares", v), nsq, vecs[v].nsq);
            chk($sformatf("vec%0d table_multiplies", v), nmul, vecs[v].nmul);
        end

        // exp=11 must issue S, S M, S M.
        check_run("exp11", 64'd11, 1, 1'b0);
        chk("exp11 op_code", r_code, 5);
        chk("exp11 op_len", r_ops.size(), 5);

        // Stray start pulses and a stray mul_done during the scan change nothing.
        check_run("disturbed", 64'd11, 1, 1'b1);
        chk("disturbed op_code", r_code, 5);

        // Reset while the first square is outstanding.
        bus.exp = 64'd11; bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        cnt = 0;
        while (!bus.mul_start && cnt < BUDGET) begin
            step();
            cnt++;
        end
        chk("midrst reached mul_start", bus.mul_start, 1);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("midrst busy", bus.busy, 0);
        chk("midrst msb_idx", longint'($signed(bus.msb_idx)), -1);
        chk("midrst mul_start", bus.mul_start, 0);
        bus.mul_done = 1'b1;
        step();
        bus.mul_done = 1'b0;
        chk("late mul_done busy", bus.busy, 0);
        chk("late mul_done mul_start", bus.mul_start, 0);
        step();
        chk("late mul_done idle", int'(bus.busy) + int'(bus.mul_start) + int'(bus.done), 0);
        check_run("post_rst exp5", 64'd5, 1, 1'b0);
        chk("post_rst op_code", r_code, 1);
        chk("post_rst op_len", r_ops.size(), 3);

        for (int k = 0; k < 20; k++) begin
            e = {$urandom, $urandom};
            e = e >> $urandom_range(0, 63);
            if (k == 5) e = '0;
            check_run($sformatf("rnd%0d", k), e, int'($urandom_range(0, 3)), k[0]);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
